jk_counter_reg: RTL and testbench
=================================

# jk_counter_reg

Parametrised WIDTH-bit register built from JK flip-flop semantics, adding modulo up/down counting, parallel load and a terminal-count pulse. It serves as the general-purpose sequential element for lab datapaths that need bitwise JK control and counter behaviour together.

## Interface

Parameters:
- WIDTH, default 4: register width in bits; legal range 1 to 32.
- MODULUS, default 16: count range is 0 to MODULUS-1. Legal range is 2 to 2**WIDTH.
- RESET_VAL, default 0: value of q after reset. Must be less than MODULUS.

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  advance enable; when low, q holds and tc = 0 on the next edge.
- mode  input  2  operation select: 00 JK, 01 up, 10 down, 11 load.
- j  input  WIDTH  per-bit J inputs; used only in JK mode.
- k  input  WIDTH  per-bit K inputs; used only in JK mode.
- d  input  WIDTH  parallel load data; used only in load mode.
- q  output  WIDTH  registered state.
- tc  output  1  registered terminal-count pulse.
- zero  output  1  combinational, equals (q == 0).

## Operation

- Reset (reset low, asynchronous):
  - q = RESET_VAL, tc = 0, immediately and independent of clk.
  - Release is sampled at the next rising edge; the first update occurs on the first edge with reset high.
- en low: q holds, tc <= 0, regardless of mode.
- en high, by mode:
  - JK (00): each bit i independently follows {j[i],k[i]}: 00 hold, 01 clear, 10 set, 11 toggle.
    - The result is stored verbatim, with no modulus check. Values of MODULUS or above are legal in this mode.
    - tc <= 0.
  - Up (01):
    - If q >= MODULUS-1, then q <= 0 and tc <= 1 (wrap).
    - Otherwise q <= q+1 and tc <= 0.
    - An out-of-range q therefore wraps to 0 and pulses tc.
  - Down (10):
    - If q == 0 or q > MODULUS-1, then q <= MODULUS-1 and tc <= 1.
    - Otherwise q <= q-1 and tc <= 0.
  - Load (11):
    - q <= d if d < MODULUS, else q <= MODULUS-1 (clamp).
    - tc <= 0.
- Arithmetic:
  - Unsigned, WIDTH bits.
  - Comparisons against MODULUS use WIDTH+1 bits, so MODULUS = 2**WIDTH is representable.
  - No intermediate carry is visible outside the block.
- mode and the data inputs (j, k, d) are sampled only on the clock edge; changes between edges have no effect.

## Timing

- All state updates occur on the rising edge of clk. Latency from sampled inputs to q and tc is 1 cycle.
- tc is a single-cycle pulse, high in the cycle after the wrapping edge. Consecutive wraps give consecutive pulses; with MODULUS = 2, continuous up counting holds tc high on every second cycle.
- zero tracks q combinationally, with zero cycles of delay from q.
- Reset mid-operation:
  - q and tc go to their reset values within the same cycle, without waiting for a clock edge.
  - Any wrap in progress is discarded; no tc pulse is produced for it.
- Mode change takes effect on the next edge. There is no pipeline state to flush.
- Throughput: one operation per cycle in every mode.

## Test plan

Parameters for all scenarios: WIDTH=4, MODULUS=10, RESET_VAL=3.

- Reset:
  - Stimulus: assert reset low between clock edges.
  - Response: q=3, tc=0 and zero=0 before the next edge; q stays 3 for two edges after release with en=0.
- Up wrap:
  - Stimulus: load d=7, then run up with en=1 for 4 edges.
  - Response: q goes 8, 9, 0, 1. tc is high only in the cycle where q=0; zero=1 in that same cycle.
- Down wrap and clamp:
  - Stimulus 1: load d=12, then 1 down edge.
  - Response 1: the load clamps q to 9; the down edge gives q=8 with tc=0.
  - Stimulus 2: from q=0, 1 down edge.
  - Response 2: q=9, tc=1.
- JK mode:
  - Stimulus: from q=4'b0101, apply j=4'b1010, k=4'b0110.
  - Response: bit 3 sets, bit 2 clears, bit 1 toggles 0→1, bit 0 holds 1, giving q=4'b1011 (11, out of range, stored verbatim). One following up edge then gives q=0, tc=1.
- Enable and mid-operation reset:
  - Stimulus 1: in up mode at q=9 with en=0, apply 3 edges.
  - Response 1: q=9 and tc=0 throughout.
  - Stimulus 2: set en=1 and assert reset low before the edge.
  - Response 2: q=3 and no tc pulse.
- Mode switch:
  - Stimulus: alternate up and down on successive edges starting at q=5.
  - Response: q toggles 6, 5, 6, 5 with tc=0 throughout.

Source files
------------

// File: rtl/jk_counter_reg.sv
// jk_counter_reg
//   WIDTH-bit register with per-bit JK control, modulo up/down counting,
//   clamped parallel load and a registered terminal-count pulse.
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-low reset (q = RESET_VAL, tc = 0)
//     en     advance enable; low holds q and clears tc on the next edge
//     mode   00 JK, 01 up, 10 down, 11 load
//     j, k   per-bit JK controls (JK mode only)
//     d      parallel load data (load mode only, clamped to MODULUS-1)
//     q      registered state
//     tc     registered terminal-count pulse (one cycle per wrap)
//     zero   combinational (q == 0)
module jk_counter_reg #(
    parameter int unsigned      WIDTH     = 4,
    parameter longint unsigned  MODULUS   = 16,
    parameter longint unsigned  RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             zero
);

    typedef enum logic [1:0] {
        MODE_JK   = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_LOAD = 2'b11
    } mode_t;

    // MODULUS may equal 2**WIDTH, so it is only held in WIDTH+1 bits.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RESET_VAL);

    mode_t            mode_e;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt;
    logic             tc_r;
    logic             tc_nxt;

    assign mode_e = mode_t'(mode);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_r  <= RST_Q;
            tc_r <= 1'b0;
        end else begin
            q_r  <= q_nxt;
            tc_r <= tc_nxt;
        end
    end

    always_comb begin
        q_nxt  = q_r;
        tc_nxt = 1'b0;
        if (en) begin
            unique case (mode_e)
                // set where J and Q is low, keep where K is low and Q is high;
                // JK=11 therefore toggles, JK=00 holds
                MODE_JK: q_nxt = (j & ~q_r) | (~k & q_r);
                // >= rather than == so an out-of-range JK result wraps too
                MODE_UP: begin
                    if (q_r >= MAX_Q) begin
                        q_nxt  = '0;
                        tc_nxt = 1'b1;
                    end else begin
                        q_nxt = q_r + WIDTH'(1);
                    end
                end
                MODE_DOWN: begin
                    if ((q_r == '0) || (q_r > MAX_Q)) begin
                        q_nxt  = MAX_Q;
                        tc_nxt = 1'b1;
                    end else begin
                        q_nxt = q_r - WIDTH'(1);
                    end
                end
                MODE_LOAD: begin
                    if ({1'b0, d} < MOD_EXT) q_nxt = d;
                    else                     q_nxt = MAX_Q;
                end
                default: ;
            endcase
        end
    end

    assign q    = q_r;
    assign tc   = tc_r;
    assign zero = (q_r == '0);

endmodule

// File: tb/tb_jk_counter_reg.sv
// tb_jk_counter_reg
//   Directed bench for jk_counter_reg (WIDTH=4, MODULUS=10, RESET_VAL=3).
//   The driver pushes hand-computed expected outputs into a queue; the
//   monitor pops one entry per falling clock edge (or on an explicit
//   mid-cycle sample request) and compares q, tc and zero.
module tb_jk_counter_reg;

    localparam logic [1:0] M_JK = 2'b00;
    localparam logic [1:0] M_UP = 2'b01;
    localparam logic [1:0] M_DN = 2'b10;
    localparam logic [1:0] M_LD = 2'b11;

    logic       clk;
    logic       reset;
    logic       en;
    logic [1:0] mode;
    logic [3:0] j;
    logic [3:0] k;
    logic [3:0] d;
    logic [3:0] q;
    logic       tc;
    logic       zero;

    typedef struct {
        string      name;
        logic [3:0] q;
        logic       tc;
    } exp_t;

    exp_t sb[$];
    event sample_ev;
    int   tests;
    int   fails;

    jk_counter_reg #(
        .WIDTH(4),
        .MODULUS(10),
        .RESET_VAL(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .mode(mode),
        .j(j),
        .k(k),
        .d(d),
        .q(q),
        .tc(tc),
        .zero(zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: one scoreboard entry per sample point.
    initial begin
        exp_t e;
        logic ez;
        forever begin
            @(negedge clk or sample_ev);
            if (sb.size() > 0) begin
                e  = sb.pop_front();
                ez = (e.q == 4'd0);
                tests++;
                if (q !== e.q) begin
                    fails++;
                    $display("FAIL %s.q got %0d want %0d", e.name, q, e.q);
                end
                tests++;
                if (tc !== e.tc) begin
                    fails++;
                    $display("FAIL %s.tc got %0b want %0b", e.name, tc, e.tc);
                end
                tests++;
                if (zero !== ez) begin
                    fails++;
                    $display("FAIL %s.zero got %0b want %0b", e.name, zero, ez);
                end
            end
        end
    end

    // Drive inputs for the next rising edge and expect the result at the
    // following falling edge.
    task automatic step(input logic e_en, input logic [1:0] m,
                        input logic [3:0] jj, input logic [3:0] kk,
                        input logic [3:0] dd, input logic [3:0] eq,
                        input logic etc, input string name);
        en   = e_en;
        mode = m;
        j    = jj;
        k    = kk;
        d    = dd;
        sb.push_back('{name, eq, etc});
        @(negedge clk);
    endtask

    // Sample immediately, between clock edges.
    task automatic chk_now(input logic [3:0] eq, input logic etc,
                           input string name);
        sb.push_back('{name, eq, etc});
        ->sample_ev;
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        en    = 1'b0;
        mode  = M_JK;
        j     = '0;
        k     = '0;
        d     = '0;

        // power-on reset and release with en low
        @(negedge clk);
        #1;
        chk_now(4'd3, 1'b0, "rst_por");
        reset = 1'b1;
        step(1'b0, M_UP, 4'd0, 4'd0, 4'd0, 4'd3, 1'b0, "rel_hold1");
        step(1'b0, M_UP, 4'd0, 4'd0, 4'd0, 4'd3, 1'b0, "rel_hold2");
        step(1'b1, M_UP, 4'd0, 4'd0, 4'd0, 4'd4, 1'b0, "up_first");

        // asynchronous reset between edges
        #1 reset = 1'b0;
        #1;
        chk_now(4'd3, 1'b0, "rst_async");
        @(negedge clk);
        reset = 1'b1;

        // up wrap
        step(1'b1, M_LD, 4'd0, 4'd0, 4'd7, 4'd7, 1'b0, "ld7");
        step(1'b1, M_UP, 4'd0, 4'd0, 4'd0, 4'd8, 1'b0, "up8");
        step(1'b1, M_UP, 4'd0, 4'd0, 4'd0, 4'd9, 1'b0, "up9");
        step(1'b1, M_UP, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, "up_wrap");
        step(1'b1, M_UP, 4'd0, 4'd0, 4'd0, 4'd1, 1'b0, "up1");

        // load clamp, down, down wrap
        step(1'b1, M_LD, 4'd0, 4'd0, 4'd12, 4'd9, 1'b0, "ld_clamp");
        step(1'b1, M_DN, 4'd0, 4'd0, 4'd0, 4'd8, 1'b0, "dn8");
        step(1'b1, M_LD, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, "ld0");
        step(1'b1, M_DN, 4'd0, 4'd0, 4'd0, 4'd9, 1'b1, "dn_wrap");

        // JK result stored verbatim, then up wraps from out of range
        step(1'b1, M_LD, 4'd0, 4'd0, 4'd5, 4'd5, 1'b0, "ld5");
        step(1'b1, M_JK, 4'b1010, 4'b0110, 4'd0, 4'b1011, 1'b0, "jk");
        step(1'b1, M_UP, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, "up_oor");

        // enable low holds at the wrap point
        step(1'b1, M_LD, 4'd0, 4'd0, 4'd9, 4'd9, 1'b0, "ld9");
        step(1'b0, M_UP, 4'd0, 4'd0, 4'd0, 4'd9, 1'b0, "en0_a");
        step(1'b0, M_UP, 4'd0, 4'd0, 4'd0, 4'd9, 1'b0, "en0_b");
        step(1'b0, M_UP, 4'd0, 4'd0, 4'd0, 4'd9, 1'b0, "en0_c");

        // reset lands before a wrapping edge: no tc pulse
        en   = 1'b1;
        mode = M_UP;
        #1 reset = 1'b0;
        #1;
        chk_now(4'd3, 1'b0, "rst_mid");
        step(1'b1, M_UP, 4'd0, 4'd0, 4'd0, 4'd3, 1'b0, "rst_mid_edge");
        reset = 1'b1;
        step(1'b0, M_UP, 4'd0, 4'd0, 4'd0, 4'd3, 1'b0, "rst_mid_rel");

        // alternating up/down
        step(1'b1, M_LD, 4'd0, 4'd0, 4'd5, 4'd5, 1'b0, "ld5b");
        step(1'b1, M_UP, 4'd0, 4'd0, 4'd0, 4'd6, 1'b0, "alt_up1");
        step(1'b1, M_DN, 4'd0, 4'd0, 4'd0, 4'd5, 1'b0, "alt_dn1");
        step(1'b1, M_UP, 4'd0, 4'd0, 4'd0, 4'd6, 1'b0, "alt_up2");
        step(1'b1, M_DN, 4'd0, 4'd0, 4'd0, 4'd5, 1'b0, "alt_dn2");

        // JK with en low is ignored
        step(1'b0, M_JK, 4'b1111, 4'b1111, 4'd0, 4'd5, 1'b0, "jk_en0");

        // drain: every pushed expectation must have been consumed
        for (int i = 0; i < 5; i++) begin
            #1;
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain pending %0d want 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
